display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Sequences the shared 8-digit multiplexed 7-segment display between the game's content sources: menu text, hero glyph, obstacle lane and score.
- Selects the source set per game state and scans digits 7..0 with ghost-suppression blanking.
- Snapshots all content once per frame so a digit never tears mid-frame, and blinks the result screen.
- Sits between the content generators and the board pins (selector/displayout).

Parameters:
- DIGIT_CYCLES, 50000: clk cycles per digit slot (1 kHz per digit at 50 MHz). Must be >= 2.
- BLANK_CYCLES, 500: leading cycles of each slot with all digits off. Must be < DIGIT_CYCLES; 0 is legal.
- BLINK_FRAMES, 64: frames per blink half-period in the RESULT state. Must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- presente  in  3  game state: 0 MENU, 1 SELECT, 2 PLAY, 3 RESULT, 4-7 unused (blank)
- display_menu  in  28  four glyphs: [27:21] leftmost .. [6:0] rightmost; active-high segments
- heroe  in  7  hero glyph, active-high segments
- display_obs  in  21  three obstacle glyphs: [20:14], [13:7], [6:0]
- display_puntaje  in  21  three score glyphs: [20:14] hundreds, [13:7] tens, [6:0] units
- displayout  out  7  segment drive, active-low (registered)
- selector  out  8  digit enables, active-low one-hot, bit 7 = leftmost (registered)
- frame_tick  out  1  one-cycle pulse on the cycle the frame snapshot is captured

Behaviour:
- Reset (asynchronous, rst_n low):
  - slot counter = 0; digit index = 7; snapshot registers = 0; blink phase = 0.
  - selector = 8'hFF, displayout = 7'h7F, frame_tick = 0.
- Slot counter counts 0..DIGIT_CYCLES-1 and wraps. On wrap, the digit index decrements 7->0 and 0 wraps to 7.
- Frame start is slot counter 0 with digit index 7. In that cycle:
  - presente and all four content buses are registered into the snapshot.
  - frame_tick = 1, asserted in the same cycle the snapshot is captured.
- All digit content derives only from the snapshot. An input change mid-frame takes effect at the next frame start.
- Output register, one-cycle latency from counter state:
  - Slot counter < BLANK_CYCLES: selector = 8'hFF, displayout = 7'h7F.
  - Otherwise: selector = ~(1 << digit index), displayout = ~glyph(digit index).
- Glyph map by snapshot state (unlisted digits = 7'h00, i.e. blank):
  - MENU: digits 7..4 = menu glyphs, left to right.
  - SELECT: digits 7..4 = menu glyphs; digit 0 = heroe.
  - PLAY: digits 7..5 = score (hundreds..units); digit 4 blank; digits 3..1 = obs [20:14], [13:7], [6:0]; digit 0 = heroe.
  - RESULT: digits 7..4 = menu glyphs; digits 2..0 = score. When blink phase = 1, all glyphs are forced blank; selector keeps scanning.
  - 4-7: all blank.
- Blink:
  - A frame counter increments at each frame start while snapshot state = RESULT.
  - On reaching BLINK_FRAMES it clears and toggles the blink phase.
  - At a frame start where the new snapshot state != RESULT, the frame counter and blink phase clear. Entering RESULT therefore always starts visible.
- Reset mid-slot: outputs are immediately forced to their reset values. Scanning restarts at digit 7 with a fresh snapshot on the first cycle after release.
- Exactly one selector bit is low at any time, or none during blanking. Two digits are never enabled simultaneously.

Test Plan (DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2):
- Reset release, presente=0, display_menu = {7'h01,7'h02,7'h04,7'h08}:
  - frame_tick at cycle 0.
  - Cycles 1-2 after: selector=FF.
  - Next 6 cycles: selector=7F, displayout=~7'h01.
  - Then 2 blank cycles, then selector=BF, displayout=~7'h02.
  - Digits 3..0 show displayout=7F.
- PLAY, heroe=7'h3F, obs={7'h40,7'h00,7'h08}, puntaje={7'h06,7'h5B,7'h4F}:
  - digit7=~06, digit6=~5B, digit5=~4F, digit4=7F.
  - digit3=~40, digit2=7F, digit1=~08, digit0=~3F.
  - Frame length = 64 cycles.
- Change heroe from 3F to 06 while digit 3 is active: digit 0 still shows ~3F that frame; ~06 appears from the next frame.
- presente 2->3 mid-frame:
  - RESULT visible for 2 frames, blank for 2 frames (displayout=7F while selector still scans), then visible again.
  - Returning to 0 clears the phase.
- Assert rst_n low while selector=EF, slot counter=5: selector=FF and displayout=7F in the same cycle. After release, the first frame_tick occurs at the first clock edge.
- Glitch check over 1000 frames: selector is never low in more than one bit, and never active during blank cycles.

Source files
------------

// File: rtl/display_scheduler_if.sv
// Content buses into the display scheduler and the multiplexed pin drive out of it.
// No flow control: the content side holds its buses valid continuously; the display side only observes.
interface display_scheduler_if;
   logic [2:0]  presente;
   logic [27:0] display_menu;
   logic [6:0]  heroe;
   logic [20:0] display_obs;
   logic [20:0] display_puntaje;
   logic [6:0]  displayout;
   logic [7:0]  selector;
   logic        frame_tick;

   modport master (
      output presente, display_menu, heroe, display_obs, display_puntaje,
      input  displayout, selector, frame_tick
   );

   modport slave (
      input  presente, display_menu, heroe, display_obs, display_puntaje,
      output displayout, selector, frame_tick
   );
endinterface

// File: rtl/display_scheduler.sv
// Scans an 8-digit 7-segment display from per-frame content snapshots; 1-cycle registered output latency.
// No backpressure: free-running scan, and content is sampled only at frame start.
module display_scheduler #(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int BLINK_FRAMES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   display_scheduler_if.slave bus_if
);

   localparam int CNT_W = $clog2(DIGIT_CYCLES);
   localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [2:0] ST_MENU   = 3'd0;
   localparam logic [2:0] ST_SELECT = 3'd1;
   localparam logic [2:0] ST_PLAY   = 3'd2;
   localparam logic [2:0] ST_RESULT = 3'd3;

   typedef struct packed {
      logic [2:0]  state;
      logic [27:0] menu;
      logic [6:0]  hero;
      logic [20:0] obs;
      logic [20:0] score;
   } snap_t;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   snap_t            snap_q, snap_d;
   logic [BF_W-1:0]  bcnt_q, bcnt_d;
   logic             blink_q, blink_d;
   logic [7:0]       sel_q, sel_d;
   logic [6:0]       seg_q, seg_d;
   logic             slot_end;
   logic             frame_start;
   logic             in_blank;

   assign slot_end    = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
   assign frame_start = (cnt_q == '0) && (idx_q == 3'd7);
   assign in_blank    = (cnt_q < CNT_W'(BLANK_CYCLES));

   function automatic logic [6:0] glyph_of(input snap_t s, input logic hide, input logic [2:0] idx);
      logic [6:0] menu_g;
      logic [6:0] g;
      menu_g = 7'h00;
      g      = 7'h00;
      case (idx)
         3'd7:    menu_g = s.menu[27:21];
         3'd6:    menu_g = s.menu[20:14];
         3'd5:    menu_g = s.menu[13:7];
         3'd4:    menu_g = s.menu[6:0];
         default: menu_g = 7'h00;
      endcase
      case (s.state)
         ST_MENU:   g = menu_g;
         ST_SELECT: g = (idx == 3'd0) ? s.hero : menu_g;
         ST_PLAY: begin
            case (idx)
               3'd7:    g = s.score[20:14];
               3'd6:    g = s.score[13:7];
               3'd5:    g = s.score[6:0];
               3'd3:    g = s.obs[20:14];
               3'd2:    g = s.obs[13:7];
               3'd1:    g = s.obs[6:0];
               3'd0:    g = s.hero;
               default: g = 7'h00;
            endcase
         end
         ST_RESULT: begin
            case (idx)
               3'd2:    g = s.score[20:14];
               3'd1:    g = s.score[13:7];
               3'd0:    g = s.score[6:0];
               default: g = menu_g;
            endcase
            // Blink hides segments only; the scan keeps running so brightness timing is unchanged.
            if (hide) begin
               g = 7'h00;
            end
         end
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   always_comb begin
      cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
      idx_d = slot_end ? idx_q - 3'd1 : idx_q;
   end

   always_comb begin
      snap_d  = snap_q;
      bcnt_d  = bcnt_q;
      blink_d = blink_q;
      if (frame_start) begin
         snap_d.state = bus_if.presente;
         snap_d.menu  = bus_if.display_menu;
         snap_d.hero  = bus_if.heroe;
         snap_d.obs   = bus_if.display_obs;
         snap_d.score = bus_if.display_puntaje;
         // Counting starts on the second RESULT frame so the first visible half lasts BLINK_FRAMES frames.
         if (bus_if.presente != ST_RESULT) begin
            bcnt_d  = '0;
            blink_d = 1'b0;
         end else if (snap_q.state == ST_RESULT) begin
            if (bcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
               bcnt_d  = '0;
               blink_d = ~blink_q;
            end else begin
               bcnt_d = bcnt_q + BF_W'(1);
            end
         end
      end
   end

   // Glyphs come from the next-state snapshot so digit 7 never shows stale content when blanking is zero.
   always_comb begin
      sel_d = 8'hFF;
      seg_d = 7'h7F;
      if (!in_blank) begin
         sel_d = ~(8'd1 << idx_q);
         seg_d = ~glyph_of(snap_d, blink_d, idx_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= 3'd7;
         snap_q  <= '0;
         bcnt_q  <= '0;
         blink_q <= 1'b0;
         sel_q   <= 8'hFF;
         seg_q   <= 7'h7F;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         bcnt_q  <= bcnt_d;
         blink_q <= blink_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
      end
   end

   assign bus_if.selector   = sel_q;
   assign bus_if.displayout = seg_q;
   assign bus_if.frame_tick = rst_n & frame_start;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with 8-cycle slots, 2 blank cycles and 2-frame blink halves.
module tb_display_scheduler;

   logic clk;
   logic rst_n;
   int   c;
   int   checks;
   int   errors;

   logic [6:0] menu_t   [7:0];
   logic [6:0] play3f_t [7:0];
   logic [6:0] play06_t [7:0];
   logic [6:0] result_t [7:0];
   logic [6:0] blank_t  [7:0];
   logic [6:0] tbl      [7:0];

   display_scheduler_if dif ();

   display_scheduler #(
      .DIGIT_CYCLES(8),
      .BLANK_CYCLES(2),
      .BLINK_FRAMES(2)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output cycle cc reflects counter state cc-1; cycle 0 is the frame-start cycle after reset release.
   function automatic logic [7:0] exp_sel(input int cc);
      logic [7:0] one;
      int k;
      one = 8'd1;
      k   = cc - 1;
      if ((k % 8) < 2) return 8'hFF;
      return ~(one << (7 - ((k / 8) % 8)));
   endfunction

   function automatic int exp_idx(input int cc);
      return 7 - (((cc - 1) / 8) % 8);
   endfunction

   function automatic bit exp_blank(input int cc);
      return ((cc - 1) % 8) < 2;
   endfunction

   task automatic tick();
      @(negedge clk);
      c++;
   endtask

   task automatic test_reset();
      rst_n               = 1'b0;
      dif.presente        = 3'd0;
      dif.display_menu    = '0;
      dif.heroe           = '0;
      dif.display_obs     = '0;
      dif.display_puntaje = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (dif.selector !== 8'hFF) begin
         errors++; $display("FAIL reset_sel got %h want ff", dif.selector);
      end
      checks++;
      if (dif.displayout !== 7'h7F) begin
         errors++; $display("FAIL reset_seg got %h want 7f", dif.displayout);
      end
      checks++;
      if (dif.frame_tick !== 1'b0) begin
         errors++; $display("FAIL reset_tick got %b want 0", dif.frame_tick);
      end
   endtask

   task automatic test_menu();
      logic [6:0] want_seg;
      dif.presente     = 3'd0;
      dif.display_menu = {7'h01, 7'h02, 7'h04, 7'h08};
      rst_n = 1'b1;
      c     = 0;
      #1;
      checks++;
      if (dif.frame_tick !== 1'b1) begin
         errors++; $display("FAIL menu_tick0 got %b want 1", dif.frame_tick);
      end
      tbl = menu_t;
      for (int i = 0; i < 64; i++) begin
         tick();
         want_seg = exp_blank(c) ? 7'h7F : ~tbl[exp_idx(c)];
         checks++;
         if (dif.selector !== exp_sel(c)) begin
            errors++; $display("FAIL menu_sel c=%0d got %h want %h", c, dif.selector, exp_sel(c));
         end
         checks++;
         if (dif.displayout !== want_seg) begin
            errors++; $display("FAIL menu_seg c=%0d got %h want %h", c, dif.displayout, want_seg);
         end
         checks++;
         if (dif.frame_tick !== (c % 64 == 0)) begin
            errors++; $display("FAIL menu_tick c=%0d got %b want %b", c, dif.frame_tick, (c % 64 == 0));
         end
      end
   endtask

   task automatic test_play();
      logic [6:0] want_seg;
      dif.presente        = 3'd2;
      dif.heroe           = 7'h3F;
      dif.display_obs     = {7'h40, 7'h00, 7'h08};
      dif.display_puntaje = {7'h06, 7'h5B, 7'h4F};
      tbl = play3f_t;
      for (int i = 0; i < 64; i++) begin
         tick();
         want_seg = exp_blank(c) ? 7'h7F : ~tbl[exp_idx(c)];
         checks++;
         if (dif.selector !== exp_sel(c)) begin
            errors++; $display("FAIL play_sel c=%0d got %h want %h", c, dif.selector, exp_sel(c));
         end
         checks++;
         if (dif.displayout !== want_seg) begin
            errors++; $display("FAIL play_seg c=%0d got %h want %h", c, dif.displayout, want_seg);
         end
         checks++;
         if (dif.frame_tick !== (c % 64 == 0)) begin
            errors++; $display("FAIL play_tick c=%0d got %b want %b", c, dif.frame_tick, (c % 64 == 0));
         end
      end
   endtask

   task automatic test_heroe_midframe();
      logic [6:0] want_seg;
      for (int i = 0; i < 128; i++) begin
         tick();
         tbl = (((c - 1) / 64) == 2) ? play3f_t : play06_t;
         want_seg = exp_blank(c) ? 7'h7F : ~tbl[exp_idx(c)];
         checks++;
         if (dif.selector !== exp_sel(c)) begin
            errors++; $display("FAIL heroe_sel c=%0d got %h want %h", c, dif.selector, exp_sel(c));
         end
         checks++;
         if (dif.displayout !== want_seg) begin
            errors++; $display("FAIL heroe_seg c=%0d got %h want %h", c, dif.displayout, want_seg);
         end
         if (c == 163) dif.heroe = 7'h06;
      end
   endtask

   task automatic test_result_blink();
      logic [6:0] want_seg;
      int f;
      for (int i = 0; i < 64 * 11; i++) begin
         tick();
         f = (c - 1) / 64;
         case (f)
            4:          tbl = play06_t;
            12:         tbl = menu_t;
            7, 8, 11:   tbl = blank_t;
            default:    tbl = result_t;
         endcase
         want_seg = exp_blank(c) ? 7'h7F : ~tbl[exp_idx(c)];
         checks++;
         if (dif.selector !== exp_sel(c)) begin
            errors++; $display("FAIL blink_sel c=%0d got %h want %h", c, dif.selector, exp_sel(c));
         end
         checks++;
         if (dif.displayout !== want_seg) begin
            errors++; $display("FAIL blink_seg c=%0d frame=%0d got %h want %h", c, f, dif.displayout, want_seg);
         end
         if (c == 286) dif.presente = 3'd3;
         if (c == 734) dif.presente = 3'd0;
         if (c == 798) dif.presente = 3'd3;
      end
   endtask

   task automatic test_reset_midslot();
      logic [6:0] want_seg;
      while (c < 989) tick();
      checks++;
      if (dif.selector !== 8'hEF) begin
         errors++; $display("FAIL midslot_pre_sel got %h want ef", dif.selector);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (dif.selector !== 8'hFF) begin
         errors++; $display("FAIL midslot_sel got %h want ff", dif.selector);
      end
      checks++;
      if (dif.displayout !== 7'h7F) begin
         errors++; $display("FAIL midslot_seg got %h want 7f", dif.displayout);
      end
      checks++;
      if (dif.frame_tick !== 1'b0) begin
         errors++; $display("FAIL midslot_tick got %b want 0", dif.frame_tick);
      end
      repeat (2) @(negedge clk);
      dif.presente = 3'd0;
      rst_n = 1'b1;
      c     = 0;
      #1;
      checks++;
      if (dif.frame_tick !== 1'b1) begin
         errors++; $display("FAIL midslot_tick0 got %b want 1", dif.frame_tick);
      end
      tbl = menu_t;
      for (int i = 0; i < 64; i++) begin
         tick();
         want_seg = exp_blank(c) ? 7'h7F : ~tbl[exp_idx(c)];
         checks++;
         if (dif.selector !== exp_sel(c)) begin
            errors++; $display("FAIL restart_sel c=%0d got %h want %h", c, dif.selector, exp_sel(c));
         end
         checks++;
         if (dif.displayout !== want_seg) begin
            errors++; $display("FAIL restart_seg c=%0d got %h want %h", c, dif.displayout, want_seg);
         end
         checks++;
         if (dif.frame_tick !== (c % 64 == 0)) begin
            errors++; $display("FAIL restart_tick c=%0d got %b want %b", c, dif.frame_tick, (c % 64 == 0));
         end
      end
   endtask

   task automatic test_glitch();
      int bad_hot;
      int bad_blank;
      int bad_sel;
      bad_hot   = 0;
      bad_blank = 0;
      bad_sel   = 0;
      for (int i = 0; i < 64000; i++) begin
         tick();
         if ($countones(~dif.selector) > 1) bad_hot++;
         if (exp_blank(c) && (dif.selector !== 8'hFF)) bad_blank++;
         if (!exp_blank(c) && (dif.selector !== exp_sel(c))) bad_sel++;
         if (i % 37 == 0) begin
            dif.presente        = 3'($urandom_range(0, 7));
            dif.display_menu    = 28'($urandom);
            dif.heroe           = 7'($urandom);
            dif.display_obs     = 21'($urandom);
            dif.display_puntaje = 21'($urandom);
         end
      end
      checks++;
      if (bad_hot !== 0) begin
         errors++; $display("FAIL glitch_multi got %0d cycles want 0", bad_hot);
      end
      checks++;
      if (bad_blank !== 0) begin
         errors++; $display("FAIL glitch_blank got %0d cycles want 0", bad_blank);
      end
      checks++;
      if (bad_sel !== 0) begin
         errors++; $display("FAIL glitch_scan got %0d cycles want 0", bad_sel);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      c        = 0;
      menu_t   = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h00, 7'h00, 7'h00, 7'h00};
      play3f_t = '{7'h06, 7'h5B, 7'h4F, 7'h00, 7'h40, 7'h00, 7'h08, 7'h3F};
      play06_t = '{7'h06, 7'h5B, 7'h4F, 7'h00, 7'h40, 7'h00, 7'h08, 7'h06};
      result_t = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h00, 7'h06, 7'h5B, 7'h4F};
      blank_t  = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
      test_reset();
      test_menu();
      test_play();
      test_heroe_midframe();
      test_result_blink();
      test_reset_midslot();
      test_glitch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
